// File: rtl/liteic_slave_node_write.sv
// Write-path slave node: round-robin arbitration of crossbar AW requests, grant held for
// a complete AW + W + B write, AW/W forwarded to one AXI-Lite slave, B returned to the owner.
module liteic_slave_node_write #(
    parameter int NUM_MASTERS  = 4,
    parameter int AWADDR_WIDTH = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BRESP_WIDTH  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [NUM_MASTERS-1:0]                cbar_aw_reqst_val_i,
    output logic [NUM_MASTERS-1:0]                cbar_aw_reqst_rdy_o,
    input  logic [AWADDR_WIDTH-1:0]               cbar_aw_reqst_data_i [NUM_MASTERS],
    input  logic [NUM_MASTERS-1:0]                cbar_w_reqst_val_i,
    output logic [NUM_MASTERS-1:0]                cbar_w_reqst_rdy_o,
    input  logic [DATA_WIDTH+DATA_WIDTH/8-1:0]    cbar_w_reqst_data_i [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0]                cbar_resp_val_o,
    input  logic [NUM_MASTERS-1:0]                cbar_resp_rdy_i,
    output logic [BRESP_WIDTH-1:0]                cbar_resp_data_o,
    output logic [AWADDR_WIDTH-1:0]               s_aw_addr_o,
    output logic                                  s_aw_valid_o,
    input  logic                                  s_aw_ready_i,
    output logic [DATA_WIDTH-1:0]                 s_w_data_o,
    output logic [DATA_WIDTH/8-1:0]               s_w_strb_o,
    output logic                                  s_w_valid_o,
    input  logic                                  s_w_ready_i,
    input  logic [BRESP_WIDTH-1:0]                s_b_resp_i,
    input  logic                                  s_b_valid_i,
    output logic                                  s_b_ready_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                         state_reg;
    logic [NUM_MASTERS-1:0]         grant_reg;
    logic [IDX_W-1:0]               rr_ptr_reg;
    logic                           aw_done_reg;
    logic                           w_done_reg;

    logic [IDX_W-1:0]               grant_idx;
    logic [IDX_W-1:0]               pick_idx;
    logic [IDX_W-1:0]               cand_idx;
    logic                           pick_found;
    logic [IDX_W-1:0]               rr_ptr_next;
    logic                           in_xfer;
    logic                           in_resp;
    logic                           aw_lane_rdy;
    logic                           w_lane_rdy;
    logic                           resp_lane_val;
    logic                           aw_hs;
    logic                           w_hs;
    logic                           b_hs;
    logic [DATA_WIDTH+DATA_WIDTH/8-1:0] w_sel;

    // Onehot grant to index; only meaningful while a grant is held.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_reg[i]) grant_idx = IDX_W'(i);
        end
    end

    // Scan from rr_ptr upward with wrap; iterating downward lets the nearest requester win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            cand_idx = IDX_W'((int'(rr_ptr_reg) + i) % NUM_MASTERS);
            if (cbar_aw_reqst_val_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign rr_ptr_next = (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;

    assign in_xfer = (state_reg == ST_XFER);
    assign in_resp = (state_reg == ST_RESP);

    assign aw_lane_rdy   = in_xfer & ~aw_done_reg & s_aw_ready_i;
    assign w_lane_rdy    = in_xfer & ~w_done_reg & s_w_ready_i;
    assign resp_lane_val = in_resp & s_b_valid_i;

    assign s_aw_valid_o = in_xfer & ~aw_done_reg & cbar_aw_reqst_val_i[grant_idx];
    assign s_w_valid_o  = in_xfer & ~w_done_reg & cbar_w_reqst_val_i[grant_idx];
    assign s_b_ready_o  = in_resp & cbar_resp_rdy_i[grant_idx];

    assign s_aw_addr_o = cbar_aw_reqst_data_i[grant_idx];
    assign w_sel       = cbar_w_reqst_data_i[grant_idx];
    assign s_w_data_o  = w_sel[DATA_WIDTH-1:0];
    assign s_w_strb_o  = w_sel[DATA_WIDTH+DATA_WIDTH/8-1:DATA_WIDTH];

    assign cbar_resp_data_o = s_b_resp_i;

    assign aw_hs = s_aw_valid_o & s_aw_ready_i;
    assign w_hs  = s_w_valid_o & s_w_ready_i;
    assign b_hs  = s_b_valid_i & s_b_ready_o;

    // Per-lane handshake signals are masked by the grant so idle masters see nothing.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
        assign cbar_aw_reqst_rdy_o[gi] = grant_reg[gi] & aw_lane_rdy;
        assign cbar_w_reqst_rdy_o[gi]  = grant_reg[gi] & w_lane_rdy;
        assign cbar_resp_val_o[gi]     = grant_reg[gi] & resp_lane_val;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            rr_ptr_reg  <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_reg <= NUM_MASTERS'(1) << pick_idx;
                        state_reg <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    aw_done_reg <= aw_done_reg | aw_hs;
                    w_done_reg  <= w_done_reg | w_hs;
                    if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (b_hs) begin
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        grant_reg   <= '0;
                        rr_ptr_reg  <= rr_ptr_next;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_liteic_slave_node_write.sv
// Randomized bench: crossbar masters and an AXI-Lite slave model drive the node; a monitor
// compares every cycle against a round-robin transaction-level reference and a scoreboard.
module tb_liteic_slave_node_write;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int BW = 2;
    localparam int WW = DW + SW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } txn_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  aw_val, aw_rdy, w_val, w_rdy, resp_val, resp_rdy;
    logic [AW-1:0] aw_data [N];
    logic [WW-1:0] w_data [N];
    logic [BW-1:0] resp_data;
    logic [AW-1:0] s_aw_addr;
    logic          s_aw_valid, s_aw_ready;
    logic [DW-1:0] s_w_data;
    logic [SW-1:0] s_w_strb;
    logic          s_w_valid, s_w_ready;
    logic [BW-1:0] s_b_resp;
    logic          s_b_valid, s_b_ready;

    int checks = 0;
    int errors = 0;
    int issued = 0;
    int completed = 0;
    bit gen_en = 1'b0;

    // Handshakes seen at the falling edge; they complete at the following rising edge.
    logic [N-1:0] hs_aw, hs_w, hs_b;
    logic         hs_saw, hs_sw, hs_sb;

    txn_t          exp_q [N][$];
    logic [BW-1:0] b_q [$];

    // Reference: owner, round-robin pointer and per-write progress.
    bit m_busy = 1'b0;
    int m_g = 0;
    int m_ptr = 0;
    bit m_aw_done = 1'b0;
    bit m_w_done = 1'b0;

    int m_phase [N];
    int m_cnt [N];
    int aw_dly [N];
    int w_dly [N];
    bit aw_sent [N];
    bit w_sent [N];
    bit got_aw = 1'b0;
    bit got_w = 1'b0;

    always #5 clk = ~clk;

    liteic_slave_node_write #(
        .NUM_MASTERS  (N),
        .AWADDR_WIDTH (AW),
        .DATA_WIDTH   (DW),
        .BRESP_WIDTH  (BW)
    ) dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .cbar_aw_reqst_val_i  (aw_val),
        .cbar_aw_reqst_rdy_o  (aw_rdy),
        .cbar_aw_reqst_data_i (aw_data),
        .cbar_w_reqst_val_i   (w_val),
        .cbar_w_reqst_rdy_o   (w_rdy),
        .cbar_w_reqst_data_i  (w_data),
        .cbar_resp_val_o      (resp_val),
        .cbar_resp_rdy_i      (resp_rdy),
        .cbar_resp_data_o     (resp_data),
        .s_aw_addr_o          (s_aw_addr),
        .s_aw_valid_o         (s_aw_valid),
        .s_aw_ready_i         (s_aw_ready),
        .s_w_data_o           (s_w_data),
        .s_w_strb_o           (s_w_strb),
        .s_w_valid_o          (s_w_valid),
        .s_w_ready_i          (s_w_ready),
        .s_b_resp_i           (s_b_resp),
        .s_b_valid_i          (s_b_valid),
        .s_b_ready_o          (s_b_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] all_handshake_outs();
        return {aw_rdy, w_rdy, resp_val, s_aw_valid, s_w_valid, s_b_ready};
    endfunction

    // Monitor and scoreboard.
    always @(negedge clk) begin
        logic [N-1:0] gmask;
        hs_aw  = aw_val & aw_rdy;
        hs_w   = w_val & w_rdy;
        hs_b   = resp_val & resp_rdy;
        hs_saw = s_aw_valid & s_aw_ready;
        hs_sw  = s_w_valid & s_w_ready;
        hs_sb  = s_b_valid & s_b_ready;
        if (!rstn) begin
            m_busy = 1'b0;
            m_ptr = 0;
            m_aw_done = 1'b0;
            m_w_done = 1'b0;
            b_q.delete();
        end else if (!m_busy) begin
            check("idle_outputs", 64'(all_handshake_outs()), 64'd0);
            if (|aw_val) begin
                for (int k = 0; k < N; k++) begin
                    if (aw_val[(m_ptr + k) % N]) begin
                        m_g = (m_ptr + k) % N;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_aw_done = 1'b0;
                m_w_done = 1'b0;
            end
        end else begin
            gmask = N'(1) << m_g;
            check("foreign_lanes", 64'((aw_rdy | w_rdy | resp_val) & ~gmask), 64'd0);
            if (exp_q[m_g].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL owner_queue actual=0 entries required=1 (master %0d)", m_g);
            end else if (!(m_aw_done && m_w_done)) begin
                check("s_aw_valid", 64'(s_aw_valid), 64'(!m_aw_done && aw_val[m_g]));
                check("aw_rdy", 64'(aw_rdy), 64'((!m_aw_done && s_aw_ready) ? gmask : '0));
                check("s_w_valid", 64'(s_w_valid), 64'(!m_w_done && w_val[m_g]));
                check("w_rdy", 64'(w_rdy), 64'((!m_w_done && s_w_ready) ? gmask : '0));
                check("xfer_b_quiet", 64'({resp_val, s_b_ready}), 64'd0);
                if (s_aw_valid) check("s_aw_addr", 64'(s_aw_addr), 64'(exp_q[m_g][0].addr));
                if (s_w_valid) begin
                    check("s_w_data", 64'(s_w_data), 64'(exp_q[m_g][0].data));
                    check("s_w_strb", 64'(s_w_strb), 64'(exp_q[m_g][0].strb));
                end
                if (hs_saw) m_aw_done = 1'b1;
                if (hs_sw) m_w_done = 1'b1;
            end else begin
                check("resp_fwd_quiet", 64'({s_aw_valid, s_w_valid, aw_rdy, w_rdy}), 64'd0);
                check("s_b_ready", 64'(s_b_ready), 64'(resp_rdy[m_g]));
                check("resp_val", 64'(resp_val), 64'(s_b_valid ? gmask : '0));
                if (s_b_valid) begin
                    if (b_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_queue actual=0 entries required=1");
                    end else begin
                        check("resp_data", 64'(resp_data), 64'(b_q[0]));
                        if (resp_rdy[m_g]) begin
                            $display("TXN master=%0d addr=%08h data=%08h strb=%h resp=%0d",
                                     m_g, exp_q[m_g][0].addr, exp_q[m_g][0].data,
                                     exp_q[m_g][0].strb, b_q[0]);
                            void'(exp_q[m_g].pop_front());
                            void'(b_q.pop_front());
                            completed++;
                            m_ptr = (m_g + 1) % N;
                            m_busy = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Crossbar-side master drivers.
    initial begin
        aw_val = '0;
        w_val = '0;
        resp_rdy = '0;
        for (int i = 0; i < N; i++) begin
            aw_data[i] = '0;
            w_data[i] = '0;
            m_phase[i] = 0;
            m_cnt[i] = i;
            aw_dly[i] = 0;
            w_dly[i] = 0;
            aw_sent[i] = 1'b0;
            w_sent[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!rstn) begin
                    if (m_phase[i] != 0) begin
                        m_phase[i] = 1;
                        aw_sent[i] = 1'b0;
                        w_sent[i] = 1'b0;
                        aw_val[i] = 1'b1;
                        w_val[i] = 1'b1;
                        resp_rdy[i] = 1'b0;
                    end
                end else begin
                    case (m_phase[i])
                        0: begin
                            if (gen_en && m_cnt[i] == 0) begin
                                txn_t t;
                                t.addr = {8'(i), 24'($urandom)};
                                t.data = DW'($urandom);
                                t.strb = SW'($urandom);
                                exp_q[i].push_back(t);
                                issued++;
                                aw_data[i] = t.addr;
                                w_data[i] = {t.strb, t.data};
                                aw_dly[i] = $urandom_range(0, 4);
                                w_dly[i] = $urandom_range(0, 4);
                                aw_sent[i] = 1'b0;
                                w_sent[i] = 1'b0;
                                m_phase[i] = 1;
                            end else if (m_cnt[i] > 0) begin
                                m_cnt[i]--;
                            end
                        end
                        1: begin
                            if (hs_aw[i]) begin aw_val[i] = 1'b0; aw_sent[i] = 1'b1; end
                            if (hs_w[i]) begin w_val[i] = 1'b0; w_sent[i] = 1'b1; end
                            if (!aw_sent[i] && !aw_val[i]) begin
                                if (aw_dly[i] == 0) aw_val[i] = 1'b1; else aw_dly[i]--;
                            end
                            if (!w_sent[i] && !w_val[i]) begin
                                if (w_dly[i] == 0) w_val[i] = 1'b1; else w_dly[i]--;
                            end
                            if (aw_sent[i] && w_sent[i]) begin
                                m_phase[i] = 2;
                                resp_rdy[i] = 1'($urandom_range(0, 1));
                            end
                        end
                        default: begin
                            if (hs_b[i]) begin
                                resp_rdy[i] = 1'b0;
                                m_phase[i] = 0;
                                m_cnt[i] = $urandom_range(0, 6);
                            end else begin
                                resp_rdy[i] = ($urandom_range(0, 2) != 0);
                            end
                        end
                    endcase
                end
            end
        end
    end

    // AXI-Lite slave model: random readies, B issued after both AW and W have landed.
    initial begin
        s_aw_ready = 1'b0;
        s_w_ready = 1'b0;
        s_b_valid = 1'b0;
        s_b_resp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                s_aw_ready = 1'b0;
                s_w_ready = 1'b0;
                s_b_valid = 1'b0;
                got_aw = 1'b0;
                got_w = 1'b0;
            end else begin
                if (hs_saw) got_aw = 1'b1;
                if (hs_sw) got_w = 1'b1;
                if (hs_sb) begin
                    s_b_valid = 1'b0;
                    got_aw = 1'b0;
                    got_w = 1'b0;
                end else if (got_aw && got_w && !s_b_valid && $urandom_range(0, 2) == 0) begin
                    s_b_resp = BW'($urandom);
                    s_b_valid = 1'b1;
                    b_q.push_back(s_b_resp);
                end
                s_aw_ready = ($urandom_range(0, 2) != 0);
                s_w_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin
        bit found;
        bit drained;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(all_handshake_outs()), 64'd0);
        @(posedge clk);
        #3 rstn = 1'b1;
        gen_en = 1'b1;
        repeat (1500) @(posedge clk);

        // Abort a write in progress with an asynchronous reset pulse.
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #3;
            if (m_busy && !(m_aw_done && m_w_done)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            errors++;
            $display("FAIL find_xfer actual=no transfer required=transfer within 500 cycles");
        end
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", 64'(all_handshake_outs()), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;

        repeat (1500) @(posedge clk);
        gen_en = 1'b0;
        drained = 1'b0;
        for (int k = 0; k < 3000 && !drained; k++) begin
            @(posedge clk);
            #2;
            drained = 1'b1;
            for (int i = 0; i < N; i++) if (m_phase[i] != 0) drained = 1'b0;
        end
        check("drained", 64'(drained), 64'd1);
        check("completed_vs_issued", 64'(completed), 64'(issued));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
